// File: rtl/single_port_ram_arbiter.sv
// rtl/single_port_ram_arbiter.sv - round-robin burst arbiter sharing one single-port sync RAM between requesters A and B
module single_port_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  A_REQ,
    input  logic                  A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_D,
    output logic                  A_GNT,
    output logic                  A_RVALID,
    output logic [DATA_WIDTH-1:0] A_Q,

    input  logic                  B_REQ,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_D,
    output logic                  B_GNT,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] B_Q,

    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_D,
    output logic                  RAM_WE,
    input  logic [DATA_WIDTH-1:0] RAM_Q
);

    localparam int               CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    // last_owner encoding: 0 = A, 1 = B
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic                    last_owner_q, last_owner_d;
    logic [ADDR_WIDTH-1:0]   hold_addr_q, hold_addr_d;
    logic                    a_rvalid_q, a_rvalid_d;
    logic                    b_rvalid_q, b_rvalid_d;

    logic                    arb_a, arb_b;
    logic                    gnt_a, gnt_b;
    logic [CNT_W-1:0]        cnt_inc;

    // Raw arbitration decision: continue the current burst, switch to the waiting side, or resolve an idle tie
    always_comb begin
        arb_a = 1'b0;
        arb_b = 1'b0;
        case (state_q)
            OWN_A: begin
                if (A_REQ && (!B_REQ || (burst_cnt_q < MAX_CNT))) begin
                    arb_a = 1'b1;
                end else if (B_REQ) begin
                    arb_b = 1'b1;
                end
            end
            OWN_B: begin
                if (B_REQ && (!A_REQ || (burst_cnt_q < MAX_CNT))) begin
                    arb_b = 1'b1;
                end else if (A_REQ) begin
                    arb_a = 1'b1;
                end
            end
            default: begin
                if (A_REQ && (!B_REQ || (last_owner_q == OWNER_B))) begin
                    arb_a = 1'b1;
                end else if (B_REQ) begin
                    arb_b = 1'b1;
                end
            end
        endcase
    end

    // Grants are suppressed while reset is held so nothing reaches the RAM
    assign gnt_a = arb_a & RST;
    assign gnt_b = arb_b & RST;
    assign A_GNT = gnt_a;
    assign B_GNT = gnt_b;

    // Burst counter increment that saturates at MAX_BURST when the owner runs uncontended
    assign cnt_inc = (burst_cnt_q == MAX_CNT) ? MAX_CNT : (burst_cnt_q + ONE_CNT);

    // Next ownership state, burst length and last-owner tracking
    always_comb begin
        state_d      = IDLE;
        burst_cnt_d  = '0;
        last_owner_d = last_owner_q;
        if (gnt_a) begin
            state_d      = OWN_A;
            burst_cnt_d  = (state_q == OWN_A) ? cnt_inc : ONE_CNT;
            last_owner_d = OWNER_A;
        end else if (gnt_b) begin
            state_d      = OWN_B;
            burst_cnt_d  = (state_q == OWN_B) ? cnt_inc : ONE_CNT;
            last_owner_d = OWNER_B;
        end
    end

    // RAM port mux: winner drives the RAM this cycle, otherwise park on the last granted address
    always_comb begin
        RAM_WE   = 1'b0;
        RAM_ADDR = hold_addr_q;
        RAM_D    = '0;
        if (gnt_a) begin
            RAM_WE   = A_WE;
            RAM_ADDR = A_ADDR;
            RAM_D    = A_D;
        end else if (gnt_b) begin
            RAM_WE   = B_WE;
            RAM_ADDR = B_ADDR;
            RAM_D    = B_D;
        end
    end

    // Datapath next-state: held address and one-cycle-delayed read strobes
    always_comb begin
        hold_addr_d = hold_addr_q;
        if (gnt_a || gnt_b) begin
            hold_addr_d = RAM_ADDR;
        end
        a_rvalid_d = gnt_a & ~A_WE;
        b_rvalid_d = gnt_b & ~B_WE;
    end

    // Arbiter FSM registers; last_owner resets to B so A wins the first tie
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            last_owner_q <= OWNER_B;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Datapath registers; reset drops any read return still in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_addr_q <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            hold_addr_q <= hold_addr_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
        end
    end

    assign A_RVALID = a_rvalid_q;
    assign B_RVALID = b_rvalid_q;
    assign A_Q      = RAM_Q;
    assign B_Q      = RAM_Q;

endmodule
